// File: rtl/mem_sram_ctrl_if.sv
// Bus between the pipeline memory stage, the SRAM controller and the 16-bit SRAM pins.
// The slave modport belongs to the controller; the master modport belongs to the core/SRAM side.
interface mem_sram_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  modport slave (
    input  mem_read, mem_write, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport master (
    output mem_read, mem_write, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Splits each 32-bit load/store into two 16-bit SRAM phases (low half, then high half),
// freezing the pipeline through ready until the access completes.
//
// state | meaning
// IDLE  | no access in flight; a request is latched and ready drops
// LOW   | SRAM access to half-word {word_addr,0}, WAIT_CYCLES+1 cycles
// HIGH  | SRAM access to half-word {word_addr,1}, WAIT_CYCLES+1 cycles
// DONE  | one-cycle ready pulse, then back to IDLE
module mem_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  mem_sram_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_e      state_q,       state_d;
  logic [2:0]  cnt_q,         cnt_d;
  logic [16:0] word_addr_q,   word_addr_d;
  logic [31:0] wdata_q,       wdata_d;
  logic        op_wr_q,       op_wr_d;
  logic [31:0] read_data_q,   read_data_d;
  logic [17:0] sram_addr_q,   sram_addr_d;
  logic        sram_we_n_q,   sram_we_n_d;
  logic [15:0] sram_dq_out_q, sram_dq_out_d;
  logic        sram_dq_oe_q,  sram_dq_oe_d;

  logic        req;
  logic        phase_last;
  logic [16:0] word_addr_calc;

  assign req            = bus.mem_read | bus.mem_write;
  assign phase_last     = (cnt_q == WAIT_LAST);
  // Subtraction wraps for addresses below BASE_ADDR; only the 17-bit word index is kept.
  assign word_addr_calc = 17'((bus.address - BASE_ADDR) >> 2);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    op_wr_d     = op_wr_q;
    read_data_d = read_data_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          word_addr_d = word_addr_calc;
          wdata_d     = bus.write_data;
          op_wr_d     = bus.mem_write;
          cnt_d       = 3'd0;
          state_d     = LOW;
        end
      end
      LOW: begin
        if (phase_last) begin
          cnt_d   = 3'd0;
          state_d = HIGH;
          if (!op_wr_q) read_data_d[15:0] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HIGH: begin
        if (phase_last) begin
          cnt_d   = 3'd0;
          state_d = DONE;
          if (!op_wr_q) read_data_d[31:16] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // SRAM pins are registered, so they are derived from the state being entered.
    sram_addr_d   = 18'd0;
    sram_we_n_d   = 1'b1;
    sram_dq_out_d = 16'd0;
    sram_dq_oe_d  = 1'b0;
    if (state_d == LOW) begin
      sram_addr_d = {word_addr_d, 1'b0};
      if (op_wr_d) begin
        sram_we_n_d   = 1'b0;
        sram_dq_oe_d  = 1'b1;
        sram_dq_out_d = wdata_d[15:0];
      end
    end else if (state_d == HIGH) begin
      sram_addr_d = {word_addr_d, 1'b1};
      if (op_wr_d) begin
        sram_we_n_d   = 1'b0;
        sram_dq_oe_d  = 1'b1;
        sram_dq_out_d = wdata_d[31:16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      word_addr_q   <= 17'd0;
      wdata_q       <= 32'd0;
      op_wr_q       <= 1'b0;
      read_data_q   <= 32'd0;
      sram_addr_q   <= 18'd0;
      sram_we_n_q   <= 1'b1;
      sram_dq_out_q <= 16'd0;
      sram_dq_oe_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_addr_q   <= word_addr_d;
      wdata_q       <= wdata_d;
      op_wr_q       <= op_wr_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
    end
  end

  // ready is combinational so the accept cycle itself already freezes the pipeline.
  assign bus.ready       = (state_q == IDLE) ? ~req : (state_q == DONE);
  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_we_n   = sram_we_n_q;
  assign bus.sram_dq_out = sram_dq_out_q;
  assign bus.sram_dq_oe  = sram_dq_oe_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=0,
// each backed by a fixed combinational SRAM data pattern.
module tb_mem_sram_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_sram_ctrl_if bus1 ();
  mem_sram_ctrl_if bus0 ();

  function automatic logic [15:0] sram_model(input logic [17:0] a);
    if (a == 18'd4) return 16'h5678;
    if (a == 18'd5) return 16'h1234;
    return a[15:0] ^ 16'h1111;
  endfunction

  assign bus1.sram_dq_in = sram_model(bus1.sram_addr);
  assign bus0.sram_dq_in = sram_model(bus0.sram_addr);

  mem_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  mem_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus1.sram_we_n !== 1'b1 || bus1.sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL rst_strobes: we_n=%b oe=%b expected we_n=1 oe=0", bus1.sram_we_n, bus1.sram_dq_oe);
    end
    checks++;
    if (bus1.sram_addr !== 18'd0 || bus1.sram_dq_out !== 16'd0) begin
      errors++; $display("FAIL rst_bus: addr=%h dq_out=%h expected 0 0", bus1.sram_addr, bus1.sram_dq_out);
    end
    checks++;
    if (bus1.read_data !== 32'd0) begin
      errors++; $display("FAIL rst_read_data: got %h expected 00000000", bus1.read_data);
    end
    checks++;
    if (bus1.ready !== 1'b1 || bus0.ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready_idle: got %b/%b expected 1/1", bus1.ready, bus0.ready);
    end
    bus1.mem_read = 1'b1;
    #1;
    checks++;
    if (bus1.ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready_req: got %b expected 0", bus1.ready);
    end
    bus1.mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    logic [17:0] exp_addr [4];
    int          low_cnt;
    exp_addr = '{18'd4, 18'd4, 18'd5, 18'd5};
    low_cnt  = 0;
    @(posedge clk); #1;
    bus1.mem_read   = 1'b1;
    bus1.address    = 32'd1032;
    bus1.write_data = 32'h1111_2222;
    @(negedge clk);
    if (bus1.ready === 1'b0) low_cnt++;
    @(posedge clk); #1;
    bus1.mem_read = 1'b0;
    bus1.address  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus1.ready === 1'b0) low_cnt++;
      checks++;
      if (bus1.sram_addr !== exp_addr[i] || bus1.sram_we_n !== 1'b1 || bus1.sram_dq_oe !== 1'b0) begin
        errors++; $display("FAIL read_phase%0d: addr=%h we_n=%b oe=%b expected addr=%h we_n=1 oe=0",
                           i, bus1.sram_addr, bus1.sram_we_n, bus1.sram_dq_oe, exp_addr[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (low_cnt != 5) begin
      errors++; $display("FAIL read_freeze_len: got %0d expected 5", low_cnt);
    end
    checks++;
    if (bus1.ready !== 1'b1 || bus1.read_data !== 32'h1234_5678) begin
      errors++; $display("FAIL read_done: ready=%b data=%h expected ready=1 data=12345678", bus1.ready, bus1.read_data);
    end
    checks++;
    if (bus1.sram_addr !== 18'd0) begin
      errors++; $display("FAIL read_done_addr: got %h expected 0", bus1.sram_addr);
    end
    @(negedge clk);
    checks++;
    if (bus1.ready !== 1'b1) begin
      errors++; $display("FAIL read_idle_ready: got %b expected 1", bus1.ready);
    end
  endtask

  task automatic test_write(input logic rd_too, input logic [31:0] wdata, input string tag);
    logic [17:0] exp_addr [4];
    logic [15:0] exp_dq   [4];
    int          we_cnt;
    exp_addr = '{18'd0, 18'd0, 18'd1, 18'd1};
    exp_dq   = '{wdata[15:0], wdata[15:0], wdata[31:16], wdata[31:16]};
    we_cnt   = 0;
    @(posedge clk); #1;
    bus1.mem_write  = 1'b1;
    bus1.mem_read   = rd_too;
    bus1.address    = 32'd1024;
    bus1.write_data = wdata;
    @(negedge clk);
    checks++;
    if (bus1.ready !== 1'b0 || bus1.sram_we_n !== 1'b1) begin
      errors++; $display("FAIL %s_accept: ready=%b we_n=%b expected 0 1", tag, bus1.ready, bus1.sram_we_n);
    end
    @(posedge clk); #1;
    bus1.mem_write  = 1'b0;
    bus1.mem_read   = 1'b0;
    bus1.write_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus1.sram_we_n === 1'b0) we_cnt++;
      checks++;
      if (bus1.sram_addr !== exp_addr[i] || bus1.sram_dq_out !== exp_dq[i] || bus1.sram_dq_oe !== 1'b1) begin
        errors++; $display("FAIL %s_phase%0d: addr=%h dq=%h oe=%b expected addr=%h dq=%h oe=1",
                           tag, i, bus1.sram_addr, bus1.sram_dq_out, bus1.sram_dq_oe, exp_addr[i], exp_dq[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (we_cnt != 4) begin
      errors++; $display("FAIL %s_we_len: got %0d expected 4", tag, we_cnt);
    end
    checks++;
    if (bus1.ready !== 1'b1 || bus1.sram_we_n !== 1'b1 || bus1.sram_dq_oe !== 1'b0 || bus1.sram_dq_out !== 16'd0) begin
      errors++; $display("FAIL %s_done: ready=%b we_n=%b oe=%b dq=%h expected 1 1 0 0000",
                         tag, bus1.ready, bus1.sram_we_n, bus1.sram_dq_oe, bus1.sram_dq_out);
    end
    checks++;
    if (bus1.read_data !== 32'h1234_5678) begin
      errors++; $display("FAIL %s_read_data_hold: got %h expected 12345678", tag, bus1.read_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] rdy_seen;
    logic [17:0] addr_c7;
    rdy_seen = '0;
    addr_c7  = '0;
    @(posedge clk); #1;
    bus1.mem_read = 1'b1;
    bus1.address  = 32'd1032;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rdy_seen[i] = bus1.ready;
      if (i == 7) addr_c7 = bus1.sram_addr;
    end
    bus1.mem_read = 1'b0;
    checks++;
    if (rdy_seen !== 12'b1000_0010_0000) begin
      errors++; $display("FAIL b2b_ready_pattern: got %b expected 100000100000", rdy_seen);
    end
    checks++;
    if (addr_c7 !== 18'd4) begin
      errors++; $display("FAIL b2b_second_low: got %h expected 4", addr_c7);
    end
    checks++;
    if (bus1.read_data !== 32'h1234_5678) begin
      errors++; $display("FAIL b2b_read_data: got %h expected 12345678", bus1.read_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    @(posedge clk); #1;
    bus1.mem_write  = 1'b1;
    bus1.address    = 32'd1024;
    bus1.write_data = 32'h0BAD_F00D;
    repeat (4) @(negedge clk);
    checks++;
    if (bus1.sram_we_n !== 1'b0 || bus1.sram_addr !== 18'd1) begin
      errors++; $display("FAIL rstmid_in_high: we_n=%b addr=%h expected 0 1", bus1.sram_we_n, bus1.sram_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus1.sram_we_n !== 1'b1 || bus1.sram_dq_oe !== 1'b0 || bus1.sram_addr !== 18'd0 || bus1.sram_dq_out !== 16'd0) begin
      errors++; $display("FAIL rstmid_abort: we_n=%b oe=%b addr=%h dq=%h expected 1 0 0 0",
                         bus1.sram_we_n, bus1.sram_dq_oe, bus1.sram_addr, bus1.sram_dq_out);
    end
    checks++;
    if (bus1.ready !== 1'b0 || bus1.read_data !== 32'd0) begin
      errors++; $display("FAIL rstmid_idle: ready=%b data=%h expected 0 00000000", bus1.ready, bus1.read_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.sram_addr !== 18'd0 || bus1.sram_we_n !== 1'b0 || bus1.sram_dq_out !== 16'hF00D || bus1.ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_restart: addr=%h we_n=%b dq=%h ready=%b expected 0 0 f00d 0",
                         bus1.sram_addr, bus1.sram_we_n, bus1.sram_dq_out, bus1.ready);
    end
    @(posedge clk); #1;
    bus1.mem_write = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus1.ready !== 1'b1 || bus1.read_data !== 32'd0) begin
      errors++; $display("FAIL rstmid_done: ready=%b data=%h expected 1 00000000", bus1.ready, bus1.read_data);
    end
  endtask

  task automatic test_wait0;
    logic [17:0] exp_addr [2];
    int          low_cnt;
    exp_addr = '{18'h3FFFE, 18'h3FFFF};
    low_cnt  = 0;
    @(posedge clk); #1;
    bus0.mem_read = 1'b1;
    bus0.address  = 32'd1020;
    @(negedge clk);
    if (bus0.ready === 1'b0) low_cnt++;
    @(posedge clk); #1;
    bus0.mem_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus0.ready === 1'b0) low_cnt++;
      checks++;
      if (bus0.sram_addr !== exp_addr[i]) begin
        errors++; $display("FAIL w0_phase%0d: addr=%h expected %h", i, bus0.sram_addr, exp_addr[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (low_cnt != 3 || bus0.ready !== 1'b1) begin
      errors++; $display("FAIL w0_freeze_len: low=%0d ready=%b expected 3 1", low_cnt, bus0.ready);
    end
    checks++;
    if (bus0.read_data !== 32'hEEEE_EEEF) begin
      errors++; $display("FAIL w0_read_data: got %h expected eeeeeeef", bus0.read_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.address = '0; bus1.write_data = '0;
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.address = '0; bus0.write_data = '0;
    test_reset;
    test_read;
    test_write(1'b0, 32'hDEAD_BEEF, "write");
    test_write(1'b1, 32'hCAFE_F00D, "rdwr");
    test_back_to_back;
    test_reset_mid_write;
    test_wait0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
